// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian-crossing controller.
package ped_pkg;

    typedef enum logic {
        ST_RED   = 1'b0,
        ST_GREEN = 1'b1
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to an active-high 7-segment code; codes above 9 go blank.
module seg7_decode
    import ped_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian-crossing controller: second prescaler, walk/stop countdown, BCD/7-seg display, frame sequencer.
// Optional LEADING_ZERO_BLANK_EN blanks 7-seg digits above the most significant non-zero digit.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int GREEN_SEC     = 15,
    parameter int RED_SEC       = 20,
    parameter int QUICK_SEC     = 5,
    parameter int DIGITS        = 2,
    parameter int ANIM_SLOW_CYC = 12500000,
    parameter int ANIM_FAST_CYC = 3125000,
    localparam int CNT_W = cnt_width((GREEN_SEC > RED_SEC) ? GREEN_SEC : RED_SEC)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause,
    input  logic                  change_state,
    output logic                  pattern,
    output logic [CNT_W-1:0]      count,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  quick,
    output logic [1:0]            sel,
    output logic                  sec_tick
);

    // state | meaning
    // RED   | stop phase, pattern=0, frame index held at 0
    // GREEN | walk phase, pattern=1, frame index animates

    localparam int SEC_W    = cnt_width(CLK_HZ - 1);
    localparam int ANIM_MAX = (ANIM_SLOW_CYC > ANIM_FAST_CYC) ? ANIM_SLOW_CYC : ANIM_FAST_CYC;
    localparam int ANIM_W   = cnt_width(ANIM_MAX);
    localparam logic [ANIM_W-1:0] SLOW_P = ANIM_W'(ANIM_SLOW_CYC);
    localparam logic [ANIM_W-1:0] FAST_P = ANIM_W'(ANIM_FAST_CYC);
    localparam logic              QUICK_AT_RST = (RED_SEC <= QUICK_SEC);

    if (GREEN_SEC < 1 || GREEN_SEC > 10**DIGITS - 1) begin : g_bad_green
        $error("GREEN_SEC out of range for DIGITS");
    end
    if (RED_SEC < 1 || RED_SEC > 10**DIGITS - 1) begin : g_bad_red
        $error("RED_SEC out of range for DIGITS");
    end
    if (QUICK_SEC == 0) begin : g_bad_quick
        $error("QUICK_SEC must be non-zero");
    end
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("DIGITS must be 1..4");
    end

    function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
        logic [4*DIGITS-1:0] r;
        int rest;
        r    = '0;
        rest = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(rest % 10);
            rest        = rest / 10;
        end
        return r;
    endfunction

    state_t              state;
    logic [SEC_W-1:0]    sec_cnt;
    logic [ANIM_W-1:0]   anim_cnt;
    logic [ANIM_W-1:0]   anim_period;
    logic                sync1, sync2, sync_prev;
    logic                sec_wrap, anim_wrap, change_edge;
    logic [DIGITS-1:0]   show;

    assign sec_wrap    = !pause && (sec_cnt == SEC_W'(CLK_HZ - 1));
    assign anim_wrap   = !pause && (anim_cnt == anim_period - ANIM_W'(1));
    assign change_edge = sync2 && !sync_prev;
    assign pattern     = (state == ST_GREEN);

    // A manual edge overrides a coincident second wrap; the animation period latches only on its own wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_RED;
            count       <= CNT_W'(RED_SEC);
            sec_cnt     <= '0;
            anim_cnt    <= '0;
            anim_period <= QUICK_AT_RST ? FAST_P : SLOW_P;
            sel         <= 2'd0;
            sec_tick    <= 1'b0;
            quick       <= QUICK_AT_RST;
            bcd         <= to_bcd(RED_SEC);
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync_prev   <= 1'b0;
        end else begin
            sync1     <= change_state;
            sync2     <= sync1;
            sync_prev <= sync2;
            sec_tick  <= sec_wrap && !change_edge;
            quick     <= (count != '0) && (int'(count) <= QUICK_SEC);
            bcd       <= to_bcd(int'(count));

            if (change_edge) begin
                state    <= (state == ST_RED) ? ST_GREEN : ST_RED;
                count    <= (state == ST_RED) ? CNT_W'(GREEN_SEC) : CNT_W'(RED_SEC);
                sec_cnt  <= '0;
                anim_cnt <= '0;
                sel      <= 2'd0;
            end else begin
                if (!pause)
                    sec_cnt <= sec_wrap ? '0 : sec_cnt + SEC_W'(1);

                if (anim_wrap) begin
                    anim_cnt    <= '0;
                    anim_period <= quick ? FAST_P : SLOW_P;
                    sel         <= (state == ST_GREEN) ? sel + 2'd1 : 2'd0;
                end else if (!pause) begin
                    anim_cnt <= anim_cnt + ANIM_W'(1);
                end

                if (sec_wrap) begin
                    if (count > CNT_W'(1)) begin
                        count <= count - CNT_W'(1);
                    end else if (state == ST_RED) begin
                        state <= ST_GREEN;
                        count <= CNT_W'(GREEN_SEC);
                    end else begin
                        state <= ST_RED;
                        count <= CNT_W'(RED_SEC);
                        sel   <= 2'd0;
                    end
                end
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic nz;
        nz   = 1'b0;
        show = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nz      = nz || (bcd[4*d +: 4] != 4'd0);
            show[d] = nz || (d == 0);
        end
    end
`else
    assign show = '1;
`endif

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [6:0] code;
        seg7_decode u_dec (
            .digit (bcd[4*d +: 4]),
            .seg   (code)
        );
        assign seg[7*d +: 7] = show[d] ? code : SEG_BLANK;
    end

endmodule
